// File: rtl/if_id_fetch_buffer_if.sv
// Fetch/decode handshake bundle for the IF->ID decoupling FIFO.
// The master drives fetch, branch and decode-stall signals; the slave is the buffer itself.
interface if_id_fetch_buffer_if;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;
  logic        if_valid_inst_out;
  logic        ex_take_branch_out;
  logic        id_stall;
  logic        PC_stall;
  logic [31:0] id_PC_out;
  logic [31:0] id_NPC_out;
  logic [31:0] id_IR_out;
  logic        id_valid_inst_out;

  modport master (
    output if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out,
    output ex_take_branch_out, id_stall,
    input  PC_stall, id_PC_out, id_NPC_out, id_IR_out, id_valid_inst_out
  );

  modport slave (
    input  if_PC_out, if_NPC_out, if_IR_out, if_valid_inst_out,
    input  ex_take_branch_out, id_stall,
    output PC_stall, id_PC_out, id_NPC_out, id_IR_out, id_valid_inst_out
  );
endinterface

// File: rtl/if_id_fetch_buffer.sv
// IF->ID instruction FIFO: buffers fetch bundles, presents the oldest to decode,
// back-pressures fetch when full and drops all wrong-path entries on a taken branch.
module if_id_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  if_id_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [95:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, flush, push, pop;
  entry_t          head;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    flush    = bus.ex_take_branch_out;
    push     = bus.if_valid_inst_out & ~full & ~flush;
    pop      = ~empty & ~flush & ~bus.id_stall;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush only resets bookkeeping; stale storage is unreachable once count is 0.
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {bus.if_PC_out, bus.if_NPC_out, bus.if_IR_out};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head data is forced to zero when empty so decode never sees a stale bundle.
  assign head                  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.PC_stall          = full;
  assign bus.id_valid_inst_out = ~empty & ~flush;
  assign bus.id_PC_out         = head[95:64];
  assign bus.id_NPC_out        = head[63:32];
  assign bus.id_IR_out         = head[31:0];
endmodule
